// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl: synchronise and debounce a push-button, latch a request until ack,
// then hold off new requests for a cooldown window.
module ped_request_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 32,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bt_raw,
  input  logic             ack,
  output logic             req,
  output logic             bt_pulse,
  output logic             busy,
  output logic [CNT_W-1:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CW = $clog2(COOLDOWN_CYCLES + 2);
  typedef enum logic [1:0] {IDLE, CHECK_HI, HELD, CHECK_LO} state_t;
  state_t state, nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0] cnt, nxt_cnt;
  logic [CW-1:0] cd;
  logic bt_s, last, press;
  assign bt_s = sync[SYNC_STAGES-1];
  assign last = cnt == DW'(DEBOUNCE_CYCLES - 1);
  assign busy = cd != '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync  <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], bt_raw};
      state <= nxt;
      cnt   <= nxt_cnt;
    end
  always_comb begin
    nxt     = state;
    nxt_cnt = cnt;
    case (state)
      IDLE:     if (bt_s) begin nxt = CHECK_HI; nxt_cnt = '0; end
      CHECK_HI: if (!bt_s) nxt = IDLE; else if (last) nxt = HELD; else nxt_cnt = cnt + 1'b1;
      HELD:     if (!bt_s) begin nxt = CHECK_LO; nxt_cnt = '0; end
      CHECK_LO: if (bt_s) nxt = HELD; else if (last) nxt = IDLE; else nxt_cnt = cnt + 1'b1;
      default:  nxt = IDLE;
    endcase
  end
  always_comb press = (state == CHECK_HI) && bt_s && last;
  // ack wins over a simultaneous press; busy is the pre-edge cooldown value
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      req         <= 1'b0;
      bt_pulse    <= 1'b0;
      cd          <= '0;
      press_count <= '0;
    end else begin
      bt_pulse <= press;
      if (req && ack) begin
        req <= 1'b0;
        cd  <= CW'(COOLDOWN_CYCLES);
      end else begin
        if (busy) cd <= cd - 1'b1;
        if (press && !req && !busy) begin
          req <= 1'b1;
          if (press_count != '1) press_count <= press_count + 1'b1;
        end
      end
    end
endmodule

// File: doc/ped_request_ctrl.md
Name: ped_request_ctrl

Overview:
- Pedestrian-button front end that sits directly upstream of the traffic-light controller and drives its button request input.
- Synchronises and debounces the raw push-button, then turns each clean press into a single-cycle pulse plus a level request.
- The request is held until the light controller acknowledges it.
- After each acknowledge, a cooldown window blocks new requests, so one pedestrian cannot keep pre-empting the green phase.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on bt_raw (minimum 2)
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed to accept a press or a release (minimum 1)
COOLDOWN_CYCLES, 32, cycles after ack during which presses are not accepted (0 = no cooldown)
CNT_W, 8, width of press_count

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-low reset
bt_raw  input  1  raw asynchronous push-button level, active-high
ack  input  1  request serviced, from light controller, sampled on clk
req  output  1  level request to light controller, held until acknowledged
bt_pulse  output  1  one-cycle strobe per debounced press
busy  output  1  cooldown active
press_count  output  CNT_W  number of accepted requests, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst=0), asynchronous: all synchroniser flops, FSM, counters and outputs clear immediately. req=0, bt_pulse=0, busy=0, press_count=0, FSM=IDLE.
- Synchroniser: bt_raw passes through SYNC_STAGES flops; bt_s is the last stage. Nothing else samples bt_raw.
- Debounce FSM, state changes on rising edge of clk; cnt is shared, width = clog2(DEBOUNCE_CYCLES)+1:
  - IDLE: bt_s=1 -> CHECK_HI, cnt=0.
  - CHECK_HI: bt_s=0 -> IDLE. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> HELD with a press event; else cnt+1.
  - HELD: bt_s=0 -> CHECK_LO, cnt=0. A long hold produces exactly one press event.
  - CHECK_LO: bt_s=1 -> HELD, no new event. Otherwise, if cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
- Press latency: define edge 1 as the first edge sampling bt_raw=1, with bt_raw stable high from then on. bt_pulse is high for exactly the one cycle following edge SYNC_STAGES+1+DEBOUNCE_CYCLES (edge 19 at defaults). bt_pulse is registered and fires regardless of req/busy.
- Request latch, evaluated each edge with priority ack > press:
  - req=1 and ack=1: req<=0, cooldown counter<=COOLDOWN_CYCLES, and any press event in the same cycle is discarded.
  - Otherwise, press event with req=0 and busy=0: req<=1 on the same edge bt_pulse is set, and press_count<=press_count+1.
  - Press event with req=1 or busy=1: merged/ignored. req unchanged, press_count unchanged.
  - ack with req=0: ignored, and does not start a cooldown.
- press_count saturates at 2^CNT_W-1 and never wraps.
- Cooldown: busy = (cooldown counter != 0). The counter decrements by 1 each cycle while nonzero. With COOLDOWN_CYCLES=0, busy never asserts.
- Cooldown expiry and press on the same edge: busy is evaluated on the pre-edge value. A press on the edge where the counter goes 1->0 is ignored; a press one cycle later is accepted.
- Glitch rejection: bt_s pulses shorter than DEBOUNCE_CYCLES produce no event. Bounces on release produce no event.
- Reset mid-operation: a pending req is dropped and the count is lost. If the button is still held when rst deasserts, it is treated as a fresh press once synchronised and debounced.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=6, SYNC_STAGES=2, CNT_W=8.)
1. Clean press: bt_raw=1 from edge 1, held for 30 cycles -> bt_pulse high only after edge 7, req=1 from edge 7, press_count=1. Release -> no second pulse.
2. Bounce: bt_raw toggles 1,0,1,0 each cycle for 8 cycles, then returns to 0 -> bt_pulse never asserts, req=0, press_count=0.
3. Handshake and cooldown: after scenario 1, ack=1 for one cycle -> req=0 next edge and busy=1 for exactly 6 cycles. A press completing debounce during busy -> bt_pulse=1, req stays 0, press_count stays 1. A press after busy falls -> req=1, press_count=2.
4. Simultaneous events: with req=1, ack=1 on the same edge as a press event -> req=0, busy=1, press_count unchanged. Also, ack with req=0 -> busy stays 0.
5. Saturation: preload via 255 press/ack cycles with COOLDOWN_CYCLES=0 -> press_count=255; one more accepted press -> press_count remains 255, req=1.
6. Reset mid-operation: req=1, busy=0, bt_raw held high, rst pulsed low for 3 cycles asynchronously mid-cycle -> outputs clear immediately. After release, req reasserts 7 edges later and press_count=1.
